// File: rtl/instr_seq_if.sv
// Handshake and control bundle between the instruction sequencer and its
// fetch port / datapath. The sequencer side is the master.
interface instr_seq_if #(
  parameter int OPW = 4,
  parameter int RW  = 2
);
  logic                  start;
  logic                  imem_req;
  logic                  imem_ack;
  logic [OPW+2*RW-1:0]   instr;
  logic                  ir_load;
  logic [OPW-1:0]        alu_op;
  logic [RW-1:0]         ra_sel;
  logic [RW-1:0]         rout;
  logic                  write;
  logic                  pc_en;
  logic                  pc_load;
  logic [OPW+2*RW-1:0]   ir_out;
  logic                  busy;
  logic                  halted;
  logic                  err;
  logic [1:0]            err_code;

  modport master (
    input  start, imem_ack, instr,
    output imem_req, ir_load, alu_op, ra_sel, rout, write, pc_en, pc_load,
           ir_out, busy, halted, err, err_code
  );

  modport slave (
    output start, imem_ack, instr,
    input  imem_req, ir_load, alu_op, ra_sel, rout, write, pc_en, pc_load,
           ir_out, busy, halted, err, err_code
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the mini-CISC core.
// Moore-decoded control outputs; ir_load is the only registered output pulse.
module instr_sequencer #(
  parameter int OPW           = 4,
  parameter int RW            = 2,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  instr_seq_if.master bus
);

  localparam int IW = OPW + 2*RW;
  localparam logic [7:0]     TO_LAST = 8'(FETCH_TIMEOUT - 1);
  localparam logic [OPW-1:0] OP_NOP  = '0;
  localparam logic [OPW-1:0] OP_JMP  = OPW'(13);
  localparam logic [OPW-1:0] OP_ILL  = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT  = OPW'(15);
  localparam logic [1:0]     EC_NONE = 2'b00;
  localparam logic [1:0]     EC_TO   = 2'b01;
  localparam logic [1:0]     EC_ILL  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ir;
  logic [7:0]      to_cnt;
  logic [1:0]      err_code_q;
  logic            ir_load_q;
  logic            capture;
  logic            timeout_hit;
  logic [OPW-1:0]  ir_op;
  logic [RW-1:0]   ir_rd;
  logic [RW-1:0]   ir_rs2;

  assign ir_op  = ir[IW-1 -: OPW];
  assign ir_rd  = ir[2*RW-1 -: RW];
  assign ir_rs2 = ir[RW-1:0];

  // An ack on the last allowed FETCH cycle still wins over the timeout.
  assign capture     = (state == S_FETCH) && bus.imem_ack;
  assign timeout_hit = (state == S_FETCH) && !bus.imem_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)      state_nxt = S_DECODE;
        else if (timeout_hit)  state_nxt = S_ERR;
      end
      S_DECODE: begin
        if (ir_op == OP_NOP || ir_op == OP_JMP) state_nxt = S_FETCH;
        else if (ir_op == OP_ILL)               state_nxt = S_ERR;
        else if (ir_op == OP_HLT)               state_nxt = S_HALT;
        else                                    state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      S_ERR:    if (bus.start) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir         <= '0;
      to_cnt     <= '0;
      err_code_q <= EC_NONE;
      ir_load_q  <= 1'b0;
    end else begin
      ir_load_q <= capture;
      if (capture) ir <= bus.instr;

      if (state == S_FETCH && !bus.imem_ack && !timeout_hit) to_cnt <= to_cnt + 8'd1;
      else                                                  to_cnt <= '0;

      if (timeout_hit)                                  err_code_q <= EC_TO;
      else if (state == S_DECODE && ir_op == OP_ILL)    err_code_q <= EC_ILL;
      else if (state == S_ERR && bus.start)             err_code_q <= EC_NONE;
    end
  end

  always_comb begin
    bus.imem_req = 1'b0;
    bus.alu_op   = '0;
    bus.ra_sel   = '0;
    bus.rout     = '0;
    bus.write    = 1'b0;
    bus.pc_en    = 1'b0;
    bus.pc_load  = 1'b0;
    bus.busy     = 1'b0;
    bus.halted   = 1'b0;
    bus.err      = 1'b0;
    case (state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.busy     = 1'b1;
      end
      S_DECODE: begin
        bus.busy    = 1'b1;
        bus.pc_en   = (ir_op == OP_NOP);
        bus.pc_load = (ir_op == OP_JMP);
      end
      S_EXEC: begin
        bus.busy   = 1'b1;
        bus.alu_op = ir_op;
        bus.ra_sel = ir_rd;
        bus.rout   = ir_rs2;
      end
      S_WB: begin
        bus.busy   = 1'b1;
        bus.alu_op = ir_op;
        bus.ra_sel = ir_rd;
        bus.rout   = ir_rs2;
        bus.write  = 1'b1;
        bus.pc_en  = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      S_ERR:   bus.err    = 1'b1;
      default: ;
    endcase
  end

  assign bus.ir_load  = ir_load_q;
  assign bus.ir_out   = ir;
  assign bus.err_code = err_code_q;

  a_pc_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(bus.pc_en && bus.pc_load));
  a_write_only_wb: assert property (@(posedge clk) disable iff (!rst)
    bus.write |-> (state == S_WB));
  a_err_code_in_err: assert property (@(posedge clk) disable iff (!rst)
    (err_code_q != EC_NONE) |-> (state == S_ERR));

endmodule
